// File: rtl/lsu_pkg.sv
// Purpose : shared types for the load/store port (size codes, request select, FSM states).
// Latency : n/a (types and pure helper functions only).
// Backpr. : n/a.
package lsu_pkg;

    // Access size field of req_sel[1:0]; RSVD is rejected as an error.
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2,
        RSVD = 2'd3
    } size_e;

    // req_sel = {signed, size}
    typedef struct packed {
        logic  sgn;
        size_e size;
    } sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    // True for accesses that must never reach the bus.
    function automatic logic is_illegal(input size_e size, input logic [1:0] addr_lo);
        case (size)
            BYTE:    is_illegal = 1'b0;
            HALF:    is_illegal = addr_lo[0];
            WORD:    is_illegal = (addr_lo != 2'b00);
            default: is_illegal = 1'b1;
        endcase
    endfunction

    // Byte enables for a store; loads always read the full word.
    function automatic logic [3:0] store_be(input size_e size, input logic [1:0] addr_lo);
        case (size)
            BYTE:    store_be = 4'b0001 << addr_lo;
            HALF:    store_be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    // Replicate right-justified store data across every lane it may land in.
    function automatic logic [31:0] store_data(input size_e size, input logic [31:0] wdata);
        case (size)
            BYTE:    store_data = {4{wdata[7:0]}};
            HALF:    store_data = {2{wdata[15:0]}};
            default: store_data = wdata;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Purpose : pick the addressed lane of a bus read word and zero/sign-extend it to 32 bits.
// Latency : purely combinational.
// Backpr. : none; output follows inputs.
// Ports   : bus_rdata_i raw bus word, addr_lo_i byte offset, sel_i {signed,size}, data_o result.
// Config  : LSU_SIGNED_LOAD_EN enables sign extension of signed byte/half loads.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] bus_rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  sel_t        sel_i,
    output logic [31:0] data_o
);

    logic       sext;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

`ifdef LSU_SIGNED_LOAD_EN
    assign sext = sel_i.sgn;
`else
    // Signed bit is accepted on the interface but every load zero-extends.
    assign sext = sel_i.sgn & 1'b0;
`endif

    always_comb begin
        lane_b = 8'h00;
        case (addr_lo_i)
            2'd0: lane_b = bus_rdata_i[7:0];
            2'd1: lane_b = bus_rdata_i[15:8];
            2'd2: lane_b = bus_rdata_i[23:16];
            2'd3: lane_b = bus_rdata_i[31:24];
            default: lane_b = 8'h00;
        endcase
        lane_h = addr_lo_i[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];

        data_o = bus_rdata_i;
        case (sel_i.size)
            BYTE:    data_o = {{24{sext & lane_b[7]}}, lane_b};
            HALF:    data_o = {{16{sext & lane_h[15]}}, lane_h};
            default: data_o = bus_rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_port.sv
// Purpose : single-outstanding load/store port bridging core accesses onto a word-wide ack bus.
// Latency : acceptance + 2 cycles plus bus wait states; illegal accesses respond at acceptance + 1.
// Backpr. : req_ready only in IDLE; bus_req held until bus_ack or TIMEOUT_CYCLES ack-less cycles.
// Ports   : req_* core request (valid/ready), rsp_* one-cycle completion pulse with error and
//           load data, bus_* word bus (req/ack handshake, byte enables, aligned address).
// Config  : LSU_SIGNED_LOAD_EN enables sign extension of signed byte/half loads.
module lsu_port
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_sel,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    sel_t          sel_q;
    logic [1:0]    addr_lo_q;
    logic          we_q;
    logic [31:0]   bus_addr_q;
    logic [31:0]   bus_wdata_q;
    logic [3:0]    bus_be_q;
    logic [31:0]   rdata_q;

    sel_t          req_sel_s;
    logic          illegal;
    logic          accept_ok;
    logic          load_done;
    logic [CW-1:0] cnt_inc;
    logic [31:0]   ext_data;

    assign req_sel_s = sel_t'(req_sel);
    assign illegal   = is_illegal(req_sel_s.size, req_addr[1:0]);
    assign cnt_inc   = cnt_q + CW'(1);

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // ---------------- FSM next state / outputs ----------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        req_ready = 1'b0;
        bus_req   = 1'b0;
        rsp_valid = 1'b0;
        accept_ok = 1'b0;
        load_done = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (illegal) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = BUS;
                        cnt_d     = '0;
                        accept_ok = 1'b1;
                    end
                end
            end
            BUS: begin
                bus_req = 1'b1;
                // Ack is checked first so a completion on the limit cycle still succeeds.
                if (bus_ack) begin
                    state_d   = RESP;
                    err_d     = 1'b0;
                    load_done = !we_q;
                end else if (cnt_inc == TO_LIM) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_err = rsp_valid & err_q;

    // ---------------- request capture and load result ----------------
    load_extend u_load_extend (
        .bus_rdata_i (bus_rdata),
        .addr_lo_i   (addr_lo_q),
        .sel_i       (sel_q),
        .data_o      (ext_data)
    );

    // Bus-facing fields are only loaded for legal accesses, so a rejected
    // request leaves the bus outputs exactly as they were.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q       <= '0;
            addr_lo_q   <= 2'b00;
            we_q        <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= 4'b0000;
            rdata_q     <= '0;
        end else begin
            if (accept_ok) begin
                sel_q       <= req_sel_s;
                addr_lo_q   <= req_addr[1:0];
                we_q        <= req_write;
                bus_addr_q  <= {req_addr[31:2], 2'b00};
                bus_wdata_q <= store_data(req_sel_s.size, req_wdata);
                bus_be_q    <= req_write ? store_be(req_sel_s.size, req_addr[1:0]) : 4'b1111;
            end
            if (load_done) begin
                rdata_q <= ext_data;
            end
        end
    end

    assign bus_we    = we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_port.sv
// Purpose : directed self-checking bench for lsu_port (stores, loads, errors, timeout, reset).
// Latency : checks the acceptance + 2 (legal) and acceptance + 1 (illegal) response timing.
// Backpr. : drives bus_ack by hand to create wait states and timeouts.
module tb_lsu_port;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_sel = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    int n_cmp = 0;
    int n_err = 0;

`ifdef LSU_SIGNED_LOAD_EN
    localparam logic [31:0] EXP_LH = 32'hFFFF8001;
    localparam logic [31:0] EXP_LB = 32'hFFFFFFF3;
`else
    localparam logic [31:0] EXP_LH = 32'h00008001;
    localparam logic [31:0] EXP_LB = 32'h000000F3;
`endif

    lsu_port #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_sel   (req_sel),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_be    (bus_be),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, summary %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1);
    end

    // Present one request for one IDLE cycle, then scramble req_* so late changes are visible.
    // Returns at the falling edge of the cycle after acceptance.
    task automatic issue(input logic w, input logic [2:0] sel, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_sel = sel; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0; req_write = ~w; req_sel = 3'b011; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if ({req_ready, rsp_valid, rsp_err, bus_req, bus_we} !== 5'b10000) begin
            n_err++; $display("FAIL reset_ctl: got %b want 10000", {req_ready, rsp_valid, rsp_err, bus_req, bus_we}); end
        n_cmp++; if ({bus_addr, bus_wdata, rsp_rdata} !== 96'h0) begin
            n_err++; $display("FAIL reset_data: got %h %h %h want 0", bus_addr, bus_wdata, rsp_rdata); end
        n_cmp++; if (bus_be !== 4'b0000) begin
            n_err++; $display("FAIL reset_be: got %b want 0000", bus_be); end
        reset = 1'b1;
    endtask

    task automatic test_store_byte();
        issue(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5);
        n_cmp++; if ({bus_req, bus_we, req_ready} !== 3'b110) begin
            n_err++; $display("FAIL stb_ctl: got %b want 110", {bus_req, bus_we, req_ready}); end
        n_cmp++; if (bus_addr !== 32'h0000_1000) begin
            n_err++; $display("FAIL stb_addr: got %h want 00001000", bus_addr); end
        n_cmp++; if (bus_be !== 4'b1000) begin
            n_err++; $display("FAIL stb_be: got %b want 1000", bus_be); end
        n_cmp++; if (bus_wdata !== 32'hA5A5_A5A5) begin
            n_err++; $display("FAIL stb_wdata: got %h want A5A5A5A5", bus_wdata); end
        @(negedge clk);  // one wait state: everything must hold
        n_cmp++; if ({bus_req, rsp_valid, bus_addr, bus_be} !== {2'b10, 32'h0000_1000, 4'b1000}) begin
            n_err++; $display("FAIL stb_wait: got req=%b rsp=%b addr=%h be=%b", bus_req, rsp_valid, bus_addr, bus_be); end
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        n_cmp++; if ({rsp_valid, rsp_err, bus_req} !== 3'b100) begin
            n_err++; $display("FAIL stb_resp: got %b want 100", {rsp_valid, rsp_err, bus_req}); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin
            n_err++; $display("FAIL stb_rdata_hold: got %h want 00000000", rsp_rdata); end
        @(negedge clk);
        n_cmp++; if ({rsp_valid, req_ready} !== 2'b01) begin
            n_err++; $display("FAIL stb_idle: got %b want 01", {rsp_valid, req_ready}); end
    endtask

    task automatic test_store_lanes();
        logic [2:0]  sel [4];
        logic [31:0] adr [4];
        logic [31:0] wd  [4];
        logic [31:0] e_a [4];
        logic [3:0]  e_be[4];
        logic [31:0] e_wd[4];
        sel[0] = 3'b001; adr[0] = 32'h12; wd[0] = 32'h1234_BEEF; e_a[0] = 32'h10; e_be[0] = 4'b1100; e_wd[0] = 32'hBEEF_BEEF;
        sel[1] = 3'b101; adr[1] = 32'h14; wd[1] = 32'hAAAA_5555; e_a[1] = 32'h14; e_be[1] = 4'b0011; e_wd[1] = 32'h5555_5555;
        sel[2] = 3'b010; adr[2] = 32'h20; wd[2] = 32'hDEAD_BEEF; e_a[2] = 32'h20; e_be[2] = 4'b1111; e_wd[2] = 32'hDEAD_BEEF;
        sel[3] = 3'b000; adr[3] = 32'h21; wd[3] = 32'hFFFF_FF3C; e_a[3] = 32'h20; e_be[3] = 4'b0010; e_wd[3] = 32'h3C3C_3C3C;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, sel[i], adr[i], wd[i]);
            n_cmp++; if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== {2'b11, e_a[i], e_be[i], e_wd[i]}) begin
                n_err++; $display("FAIL store_lane%0d: got req=%b we=%b addr=%h be=%b wd=%h want addr=%h be=%b wd=%h",
                                  i, bus_req, bus_we, bus_addr, bus_be, bus_wdata, e_a[i], e_be[i], e_wd[i]); end
            bus_ack = 1'b1;
            @(negedge clk);
            bus_ack = 1'b0;
            n_cmp++; if ({rsp_valid, rsp_err} !== 2'b10) begin
                n_err++; $display("FAIL store_lane%0d_resp: got %b want 10", i, {rsp_valid, rsp_err}); end
            @(negedge clk);
        end
    endtask

    task automatic test_load_extend();
        logic [2:0]  sel [5];
        logic [31:0] adr [5];
        logic [31:0] rd  [5];
        logic [31:0] exp_d [5];
        sel[0] = 3'b101; adr[0] = 32'h2002; rd[0] = 32'h8001_1234; exp_d[0] = EXP_LH;
        sel[1] = 3'b001; adr[1] = 32'h2000; rd[1] = 32'h8001_9234; exp_d[1] = 32'h0000_9234;
        sel[2] = 3'b100; adr[2] = 32'h0041; rd[2] = 32'h1122_F344; exp_d[2] = EXP_LB;
        sel[3] = 3'b000; adr[3] = 32'h0043; rd[3] = 32'h9A00_0000; exp_d[3] = 32'h0000_009A;
        sel[4] = 3'b110; adr[4] = 32'h0044; rd[4] = 32'h8765_4321; exp_d[4] = 32'h8765_4321;
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, sel[i], adr[i], 32'hFFFF_FFFF);
            n_cmp++; if ({bus_req, bus_we, bus_be, bus_addr} !== {2'b10, 4'b1111, adr[i] & 32'hFFFF_FFFC}) begin
                n_err++; $display("FAIL load%0d_bus: got req=%b we=%b be=%b addr=%h", i, bus_req, bus_we, bus_be, bus_addr); end
            bus_ack = 1'b1; bus_rdata = rd[i];
            @(negedge clk);
            bus_ack = 1'b0; bus_rdata = 32'hDEAD_0000;
            n_cmp++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, exp_d[i]}) begin
                n_err++; $display("FAIL load%0d_resp: got v=%b e=%b d=%h want d=%h", i, rsp_valid, rsp_err, rsp_rdata, exp_d[i]); end
            @(negedge clk);
            n_cmp++; if ({rsp_valid, rsp_rdata} !== {1'b0, exp_d[i]}) begin
                n_err++; $display("FAIL load%0d_hold: got v=%b d=%h want d=%h", i, rsp_valid, rsp_rdata, exp_d[i]); end
        end
    endtask

    // Misaligned / reserved accesses; bus_ack is held high the whole time and must be ignored.
    task automatic test_illegal();
        logic [2:0]  sel [3];
        logic [31:0] adr [3];
        logic        wr  [3];
        int          req_seen;
        sel[0] = 3'b010; adr[0] = 32'h3001; wr[0] = 1'b0;
        sel[1] = 3'b001; adr[1] = 32'h3003; wr[1] = 1'b1;
        sel[2] = 3'b011; adr[2] = 32'h3000; wr[2] = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h0BAD_0BAD;
        for (int i = 0; i < 3; i++) begin
            req_seen = 0;
            issue(wr[i], sel[i], adr[i], 32'h1111_1111);
            if (bus_req) req_seen++;
            n_cmp++; if ({rsp_valid, rsp_err} !== 2'b11) begin
                n_err++; $display("FAIL illegal%0d_resp: got %b want 11", i, {rsp_valid, rsp_err}); end
            n_cmp++; if (rsp_rdata !== 32'h8765_4321) begin
                n_err++; $display("FAIL illegal%0d_rdata: got %h want 87654321", i, rsp_rdata); end
            @(negedge clk);
            if (bus_req) req_seen++;
            n_cmp++; if ({req_seen, rsp_valid, req_ready} !== {32'd0, 2'b01}) begin
                n_err++; $display("FAIL illegal%0d_idle: bus_req cycles %0d rsp=%b rdy=%b want 0 0 1", i, req_seen, rsp_valid, req_ready); end
        end
        bus_ack = 1'b0;
    endtask

    task automatic test_timeout();
        int hi = 0;
        issue(1'b0, 3'b010, 32'h50, 32'h0);
        for (int i = 0; i < 16; i++) begin
            if (bus_req) hi++;
            @(negedge clk);
        end
        n_cmp++; if (hi !== 16) begin
            n_err++; $display("FAIL timeout_req_cycles: got %0d want 16", hi); end
        n_cmp++; if ({bus_req, rsp_valid, rsp_err} !== 3'b011) begin
            n_err++; $display("FAIL timeout_resp: got %b want 011", {bus_req, rsp_valid, rsp_err}); end
        n_cmp++; if (rsp_rdata !== 32'h8765_4321) begin
            n_err++; $display("FAIL timeout_rdata: got %h want 87654321", rsp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_ack_at_limit();
        issue(1'b0, 3'b010, 32'h60, 32'h0);
        for (int i = 0; i < 15; i++) @(negedge clk);
        n_cmp++; if (bus_req !== 1'b1) begin
            n_err++; $display("FAIL limit_req16: got %b want 1", bus_req); end
        bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus_ack = 1'b0;
        n_cmp++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hCAFE_F00D}) begin
            n_err++; $display("FAIL limit_resp: got v=%b e=%b d=%h want 1 0 CAFEF00D", rsp_valid, rsp_err, rsp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int not_rdy = 0;
        issue(1'b0, 3'b010, 32'h70, 32'h0);
        for (int i = 0; i < 3; i++) @(negedge clk);
        n_cmp++; if (bus_req !== 1'b1) begin
            n_err++; $display("FAIL rstmid_busy: got %b want 1", bus_req); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if ({bus_req, rsp_valid, req_ready, rsp_rdata} !== {3'b001, 32'h0}) begin
            n_err++; $display("FAIL rstmid_abort: got req=%b rsp=%b rdy=%b d=%h", bus_req, rsp_valid, req_ready, rsp_rdata); end
        @(negedge clk);
        reset = 1'b1;
        bus_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
            if (!req_ready) not_rdy++;
        end
        bus_ack = 1'b0;
        n_cmp++; if ({pulses, not_rdy} !== 64'd0) begin
            n_err++; $display("FAIL rstmid_after: rsp pulses %0d, not-ready cycles %0d, want 0 0", pulses, not_rdy); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_sel = 3'b010; req_addr = 32'h80;
        @(negedge clk);
        req_addr = 32'h84;  // second request, held while the first is in flight
        n_cmp++; if ({req_ready, bus_req, bus_addr} !== {2'b01, 32'h80}) begin
            n_err++; $display("FAIL b2b_first_bus: got rdy=%b req=%b addr=%h want 0 1 00000080", req_ready, bus_req, bus_addr); end
        bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
        @(negedge clk);
        bus_ack = 1'b0;
        n_cmp++; if ({rsp_valid, req_ready, rsp_rdata} !== {2'b10, 32'h1111_1111}) begin
            n_err++; $display("FAIL b2b_first_resp: got v=%b rdy=%b d=%h", rsp_valid, req_ready, rsp_rdata); end
        @(negedge clk);
        n_cmp++; if ({req_ready, bus_req} !== 2'b10) begin
            n_err++; $display("FAIL b2b_idle: got rdy=%b req=%b want 1 0", req_ready, bus_req); end
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++; if ({bus_req, bus_addr} !== {1'b1, 32'h84}) begin
            n_err++; $display("FAIL b2b_second_bus: got req=%b addr=%h want 1 00000084", bus_req, bus_addr); end
        bus_rdata = 32'h2222_2222;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if ({bus_req, rsp_rdata} !== {1'b1, 32'h1111_1111}) begin
            n_err++; $display("FAIL b2b_hold: got req=%b d=%h want 1 11111111", bus_req, rsp_rdata); end
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        n_cmp++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h2222_2222}) begin
            n_err++; $display("FAIL b2b_second_resp: got v=%b e=%b d=%h", rsp_valid, rsp_err, rsp_rdata); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_store_lanes();
        test_load_extend();
        test_illegal();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_port.md
LSU_PORT -- requirements
Module: lsu_port

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum cycles bus_req is held without bus_ack before aborting.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  in  1  core presents a memory access.
REQ-005 SHALL have port req_ready  out  1  block accepts an access.
REQ-006 SHALL have port req_write  in  1  1 = store, 0 = load (core MemW).
REQ-007 SHALL have port req_sel  in  3  {signed, size}; size 0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-008 SHALL have port req_addr  in  32  byte address.
REQ-009 SHALL have port req_wdata  in  32  store data, right-justified.
REQ-010 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_err  out  1  qualifies rsp_valid: misaligned, reserved-size or timeout.
REQ-012 SHALL have port rsp_rdata  out  32  extended load result.
REQ-013 SHALL have ports bus_req out 1, bus_we out 1, bus_addr out 32 (addr[1:0] = 0), bus_wdata out 32, bus_be out 4, bus_ack in 1, bus_rdata in 32, forming the word-wide memory bus.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, BUS, RESP.
REQ-015 req_ready SHALL equal 1 only in IDLE; an access is accepted on a cycle where req_valid and req_ready are both 1.
REQ-016 On acceptance, the block SHALL register the request fields; later req_* changes SHALL have no effect until the block returns to IDLE.
REQ-017 Accept with a legal aligned access SHALL move to BUS. bus_req SHALL be 1 from the next cycle until the bus_ack cycle, inclusive. All bus outputs SHALL stay stable while bus_req is 1.
REQ-018 An access is misaligned when size = half and addr[0] = 1, or size = word and addr[1:0] != 0. A misaligned or size = 3 access SHALL skip BUS, go straight to RESP, set rsp_err = 1, and never assert bus_req.
REQ-019 Store lane steering:
  - byte: bus_be = 1 << addr[1:0]; bus_wdata = wdata[7:0] replicated ×4.
  - half: bus_be = 0011 (addr[1] = 0) or 1100 (addr[1] = 1); bus_wdata = wdata[15:0] replicated ×2.
  - word: bus_be = 1111; bus_wdata = wdata.
REQ-020 For loads, bus_be SHALL be 1111 and bus_we SHALL be 0.
REQ-021 BUS to RESP SHALL occur on bus_ack = 1. For loads, the selected lane of bus_rdata SHALL be captured and extended per the configuration into rsp_rdata.
REQ-022 A wait counter SHALL count cycles in BUS with bus_ack = 0. When the count reaches TIMEOUT_CYCLES, bus_req SHALL drop and the FSM SHALL go to RESP with rsp_err = 1. The counter SHALL clear on entry to BUS.
REQ-023 If bus_ack arrives on the same cycle the count reaches its limit, the ack SHALL win: normal completion, rsp_err = 0.
REQ-024 RESP SHALL last exactly one cycle with rsp_valid = 1, then return to IDLE. Minimum load/store latency is acceptance + 2 cycles, plus bus wait states.
REQ-025 rsp_rdata SHALL change only on a successful load completion and SHALL hold otherwise. Stores and errors leave it unchanged.
REQ-026 bus_ack outside BUS SHALL be ignored.

Reset
REQ-027 While reset = 0, the FSM SHALL be IDLE and the wait counter 0.
REQ-028 While reset = 0, outputs SHALL be: req_ready = 1; rsp_valid, rsp_err, bus_req, bus_we = 0; rsp_rdata, bus_addr, bus_wdata = 0; bus_be = 0000.
REQ-029 Reset asserted mid-access SHALL abort the access immediately with no response pulse.

Configuration
REQ-030 With LSU_SIGNED_LOAD_EN defined, byte and half loads with signed = 1 SHALL sign-extend. Without it, the signed bit SHALL be ignored and all loads zero-extend. Word loads are unaffected in both cases.

Structure
REQ-031 Package lsu_pkg SHALL hold the size encodings (BYTE, HALF, WORD), the FSM state enum and the req_sel field typedef.
REQ-032 Lane selection and extension of load data SHALL be a combinational sub-module load_extend.

Verification
REQ-033 Store byte: addr 0x1003, wdata 0x000000A5 → bus_addr 0x1000, bus_be 1000, bus_wdata 0xA5A5A5A5, rsp_valid 1 cycle after ack.
REQ-034 Signed load half: addr 0x2002, bus_rdata 0x8001_1234 → with macro, rsp_rdata 0xFFFF8001; without macro, 0x00008001.
REQ-035 Misaligned word: load at addr 0x3001 → bus_req never 1, rsp_valid with rsp_err = 1 at acceptance + 1.
REQ-036 Timeout: bus_ack held 0 → bus_req drops after 16 cycles, rsp_err = 1. Ack on cycle 16 → success, rsp_err = 0.
REQ-037 Reset: assert reset during BUS with 3 wait states → bus_req = 0 immediately, no rsp_valid, req_ready = 1 after release.
REQ-038 Back-to-back: req_valid held high for two word loads → second accepted only in IDLE after the first RESP; rsp_rdata holds across the second access's wait states.
